// File: rtl/morse_decoder_controller.sv
`timescale 1ns/1ps
// morse_decoder_controller
//   Single-key Morse decoder. Key press length (in ms ticks) selects dot or
//   dash. An idle gap after release commits the pending letter into an
//   eight-slot ASCII history (slot 0 = newest). A backspace edge either
//   deletes the newest committed character (when idle) or discards the
//   letter currently being keyed.
//
//   Optional feature macro: MORSE_SIDETONE_EN
//     defined   -> beep is a TONE_HZ square wave while the key is held in PRESS
//     undefined -> beep tied low, no tone divider
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous reset, active low
//   key_in     in   1   debounced key level, 1 = pressed
//   backspace  in   1   debounced backspace level, acts on rising edge
//   seg_enc    out  64  eight ASCII slots, slot i at [8i+7:8i]
//   sym_len    out  3   symbols in the pending letter (0-5)
//   sym_bits   out  5   pending symbols, newest at bit 0, 1 = dash
//   char_valid out  1   one-cycle pulse, aligned with the updated seg_enc
//   beep       out  1   sidetone
module morse_decoder_controller #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int DASH_MS  = 300,
  parameter int GAP_MS   = 800,
  parameter int TONE_HZ  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_in,
  input  logic        backspace,
  output logic [63:0] seg_enc,
  output logic [2:0]  sym_len,
  output logic [4:0]  sym_bits,
  output logic        char_valid,
  output logic        beep
);

  localparam int PRE_DIV = (CLK_FREQ / 1000 > 1) ? CLK_FREQ / 1000 : 2;
  localparam int PRE_W   = $clog2(PRE_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_DIV - 1);
  localparam logic [15:0] DASH_T = 16'(DASH_MS);
  localparam logic [15:0] GAP_T  = 16'(GAP_MS);

  // Elaboration-time configuration guard
  if (CLK_FREQ < 2000 || TONE_HZ < 1) begin : g_bad_cfg
    $error("morse_decoder_controller: CLK_FREQ must be >= 2000 and TONE_HZ >= 1");
  end

  typedef enum logic [2:0] {IDLE, PRESS, GAP, COMMIT, WAIT_REL} state_t;

  state_t            r_state, w_nxt;
  logic [PRE_W-1:0]  r_pre;
  logic [15:0]       r_cnt;
  logic [63:0]       r_slots;
  logic [2:0]        r_len;
  logic [4:0]        r_bits;
  logic              r_ovf;
  logic              r_bs_q;
  logic              r_char_valid;

  logic w_tick, w_bs_edge, w_dash;
  logic w_cnt_clr, w_append, w_discard, w_commit, w_bs_shift;
  logic [7:0] w_char;

  assign w_tick    = (r_pre == PRE_MAX);
  assign w_bs_edge = backspace & ~r_bs_q;
  assign w_dash    = (r_cnt >= DASH_T);

  // International Morse lookup. Codes are read first-symbol-first from the
  // top of the valid bit range, since the newest symbol sits at bit 0.
  function automatic logic [7:0] f_decode(input logic [2:0] len,
                                          input logic [4:0] bits,
                                          input logic       ovf);
    logic [7:0] ch;
    ch = 8'h3F;
    if (!ovf) begin
      case (len)
        3'd1: ch = bits[0] ? 8'h54 : 8'h45;                  // T E
        3'd2: case (bits[1:0])
          2'b00: ch = 8'h49;                                 // I
          2'b01: ch = 8'h41;                                 // A
          2'b10: ch = 8'h4E;                                 // N
          default: ch = 8'h4D;                               // M
        endcase
        3'd3: case (bits[2:0])
          3'b000: ch = 8'h53;  3'b001: ch = 8'h55;           // S U
          3'b010: ch = 8'h52;  3'b011: ch = 8'h57;           // R W
          3'b100: ch = 8'h44;  3'b101: ch = 8'h4B;           // D K
          3'b110: ch = 8'h47;  default: ch = 8'h4F;          // G O
        endcase
        3'd4: case (bits[3:0])
          4'b0000: ch = 8'h48; 4'b0001: ch = 8'h56;          // H V
          4'b0010: ch = 8'h46; 4'b0100: ch = 8'h4C;          // F L
          4'b0110: ch = 8'h50; 4'b0111: ch = 8'h4A;          // P J
          4'b1000: ch = 8'h42; 4'b1001: ch = 8'h58;          // B X
          4'b1010: ch = 8'h43; 4'b1011: ch = 8'h59;          // C Y
          4'b1100: ch = 8'h5A; 4'b1101: ch = 8'h51;          // Z Q
          default: ch = 8'h3F;
        endcase
        3'd5: case (bits)
          5'b01111: ch = 8'h31; 5'b00111: ch = 8'h32;
          5'b00011: ch = 8'h33; 5'b00001: ch = 8'h34;
          5'b00000: ch = 8'h35; 5'b10000: ch = 8'h36;
          5'b11000: ch = 8'h37; 5'b11100: ch = 8'h38;
          5'b11110: ch = 8'h39; 5'b11111: ch = 8'h30;
          default:  ch = 8'h3F;
        endcase
        default: ch = 8'h3F;
      endcase
    end
    return ch;
  endfunction

  assign w_char = f_decode(r_len, r_bits, r_ovf);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nxt;
  end

  // Next state and datapath controls
  always_comb begin
    w_nxt      = r_state;
    w_cnt_clr  = 1'b0;
    w_append   = 1'b0;
    w_discard  = 1'b0;
    w_commit   = 1'b0;
    w_bs_shift = 1'b0;
    case (r_state)
      IDLE: begin
        w_bs_shift = w_bs_edge;
        if (key_in) begin
          w_nxt     = PRESS;
          w_cnt_clr = 1'b1;
        end
      end
      PRESS: begin
        // Backspace beats a simultaneous release: the press is thrown away.
        if (w_bs_edge) begin
          w_discard = 1'b1;
          w_nxt     = WAIT_REL;
        end else if (!key_in) begin
          w_append  = 1'b1;
          w_cnt_clr = 1'b1;
          w_nxt     = GAP;
        end
      end
      GAP: begin
        // Gap expiry wins over a new press or backspace in the same cycle.
        if (r_cnt >= GAP_T) begin
          w_nxt = COMMIT;
        end else if (w_bs_edge) begin
          w_discard = 1'b1;
          w_nxt     = IDLE;
        end else if (key_in) begin
          w_cnt_clr = 1'b1;
          w_nxt     = PRESS;
        end
      end
      COMMIT: begin
        // Any backspace edge seen here is intentionally dropped.
        w_commit = 1'b1;
        w_nxt    = IDLE;
      end
      WAIT_REL: begin
        if (!key_in) w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  // Free-running 1 ms prescaler and ms counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_cnt_clr)
        r_cnt <= '0;
      else if (w_tick && (r_state == PRESS || r_state == GAP) && r_cnt != 16'hFFFF)
        r_cnt <= r_cnt + 16'd1;
    end
  end

  // Pending letter, history slots and commit pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slots      <= '0;
      r_len        <= '0;
      r_bits       <= '0;
      r_ovf        <= 1'b0;
      r_bs_q       <= 1'b0;
      r_char_valid <= 1'b0;
    end else begin
      r_bs_q       <= backspace;
      r_char_valid <= w_commit;
      if (w_append) begin
        if (r_len == 3'd5) begin
          r_ovf <= 1'b1;
        end else begin
          r_bits <= {r_bits[3:0], w_dash};
          r_len  <= r_len + 3'd1;
        end
      end
      if (w_discard || w_commit) begin
        r_len  <= '0;
        r_bits <= '0;
        r_ovf  <= 1'b0;
      end
      if (w_commit)
        r_slots <= {r_slots[55:0], w_char};
      else if (w_bs_shift)
        r_slots <= {8'h00, r_slots[63:8]};
    end
  end

`ifdef MORSE_SIDETONE_EN
  localparam int TONE_HALF = (CLK_FREQ / (2 * TONE_HZ) > 1) ? CLK_FREQ / (2 * TONE_HZ) : 2;
  localparam int TONE_W    = $clog2(TONE_HALF);
  localparam logic [TONE_W-1:0] TONE_MAX = TONE_W'(TONE_HALF - 1);

  logic [TONE_W-1:0] r_tone_cnt;
  logic              r_beep;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tone_cnt <= '0;
      r_beep     <= 1'b0;
    end else if (r_state == PRESS && key_in) begin
      if (r_tone_cnt == TONE_MAX) begin
        r_tone_cnt <= '0;
        r_beep     <= ~r_beep;
      end else begin
        r_tone_cnt <= r_tone_cnt + 1'b1;
      end
    end else begin
      r_tone_cnt <= '0;
      r_beep     <= 1'b0;
    end
  end

  assign beep = r_beep;
`else
  assign beep = 1'b0;
`endif

  assign seg_enc    = r_slots;
  assign sym_len    = r_len;
  assign sym_bits   = r_bits;
  assign char_valid = r_char_valid;

endmodule

// File: tb/tb_morse_decoder_controller.sv
`timescale 1ns/1ps
module tb_morse_decoder_controller;

  localparam int CF = 10_000;
  localparam int DM = 3;
  localparam int GM = 8;
  localparam int TH = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_in = 1'b0;
  logic        backspace = 1'b0;
  logic [63:0] seg_enc;
  logic [2:0]  sym_len;
  logic [4:0]  sym_bits;
  logic        char_valid;
  logic        beep;

  morse_decoder_controller #(
    .CLK_FREQ(CF), .DASH_MS(DM), .GAP_MS(GM), .TONE_HZ(TH)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .backspace(backspace),
    .seg_enc(seg_enc), .sym_len(sym_len), .sym_bits(sym_bits),
    .char_valid(char_valid), .beep(beep)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] m_slots;
  logic [63:0] mon_exp;

  // Scoreboard monitor: every commit pulse must match the next queued image
  always @(negedge clk) begin
    if (char_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected: got seg_enc=%h, required no commit", seg_enc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (seg_enc !== mon_exp) begin
          errors++;
          $display("FAIL commit_slots: got seg_enc=%h, required %h", seg_enc, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // 10-cycle press is always a dot (<=1 ms tick), 40-cycle press a dash (>=3)
  task automatic sym(input bit dash);
    key_in = 1'b1;
    cyc(dash ? 40 : 10);
    key_in = 1'b0;
    cyc(20);
  endtask

  task automatic expect_char(input logic [7:0] ch);
    m_slots = {m_slots[55:0], ch};
    exp_q.push_back(m_slots);
  endtask

  task automatic letter(input string code, input logic [7:0] ch);
    expect_char(ch);
    for (int i = 0; i < code.len(); i++) sym(code[i] == 8'h2D);
    cyc(100);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    m_slots = '0;
    cyc(1);
  endtask

  int toggles;
  int highs;
  logic prev_beep;

  initial begin
    m_slots = '0;
    cyc(3);
    chk("reset_slots", seg_enc, 64'h0);
    chk("reset_len", 64'(sym_len), 64'h0);
    chk("reset_bits", 64'(sym_bits), 64'h0);
    chk("reset_valid", 64'(char_valid), 64'h0);
    chk("reset_beep", 64'(beep), 64'h0);
    rst = 1'b1;
    cyc(2);

    // backspace with an empty history
    backspace = 1'b1; cyc(3); backspace = 1'b0; cyc(2);
    chk("bs_blank", seg_enc, 64'h0);

    // dot + dash pending, then 'A'
    sym(1'b0);
    key_in = 1'b1; cyc(40); key_in = 1'b0; cyc(2);
    chk("pend_len_A", 64'(sym_len), 64'd2);
    chk("pend_bits_A", 64'(sym_bits), 64'h01);
    expect_char(8'h41);
    cyc(90);
    chk("slot0_A", 64'(seg_enc[7:0]), 64'h41);
    chk("A_committed", 64'(exp_q.size()), 64'd0);
    cyc(20);

    letter(".....", 8'h35);
    // six dots: overflow holds length, commits '?'
    expect_char(8'h3F);
    for (int i = 0; i < 6; i++) sym(1'b0);
    chk("ovf_len", 64'(sym_len), 64'd5);
    chk("ovf_bits", 64'(sym_bits), 64'h00);
    cyc(100);
    chk("cleared_len", 64'(sym_len), 64'd0);

    // backspace during a press: discard, wait for release, no commit
    sym(1'b0);
    key_in = 1'b1; cyc(5);
    backspace = 1'b1; cyc(5); backspace = 1'b0;
    chk("bs_press_len", 64'(sym_len), 64'd0);
    cyc(5); key_in = 1'b0; cyc(120);
    chk("bs_press_norel", 64'(sym_len), 64'd0);

    // backspace during the gap: discard, no commit
    sym(1'b0);
    backspace = 1'b1; cyc(2); backspace = 1'b0; cyc(1);
    chk("bs_gap_len", 64'(sym_len), 64'd0);
    cyc(120);
    chk("bs_gap_slots", seg_enc, m_slots);

    // E T A then backspace removes 'A'
    do_reset();
    letter(".", 8'h45);
    letter("-", 8'h54);
    letter(".-", 8'h41);
    backspace = 1'b1; cyc(2); backspace = 1'b0; cyc(2);
    chk("bs_idle_slots", seg_enc, 64'h0000_0000_0000_4554);

    // nine letters: the first falls off slot 7
    do_reset();
    letter(".", 8'h45);  letter("-", 8'h54);  letter("..", 8'h49);
    letter(".-", 8'h41); letter("-.", 8'h4E); letter("--", 8'h4D);
    letter("...", 8'h53); letter("..-", 8'h55); letter(".-.", 8'h52);
    chk("nine_slot7", 64'(seg_enc[63:56]), 64'h54);
    chk("nine_slot0", 64'(seg_enc[7:0]), 64'h52);

    // reset during a press: outputs clear at once, released press not captured
    key_in = 1'b1; cyc(10);
    #2 rst = 1'b0;
    #1;
    chk("async_slots", seg_enc, 64'h0);
    chk("async_len", 64'(sym_len), 64'h0);
    chk("async_valid", 64'(char_valid), 64'h0);
    m_slots = '0;
    cyc(9); key_in = 1'b0; cyc(5);
    rst = 1'b1;
    cyc(120);
    chk("rst_press_len", 64'(sym_len), 64'h0);
    chk("rst_press_slots", seg_enc, 64'h0);

    // key still high at reset release counts as a new press -> 'E'
    key_in = 1'b1; cyc(5);
    rst = 1'b0; cyc(3); rst = 1'b1;
    cyc(10); key_in = 1'b0; cyc(2);
    chk("rst_newpress_len", 64'(sym_len), 64'd1);
    expect_char(8'h45);
    cyc(100);

    // sidetone during a long (dash) press -> 'T'
    expect_char(8'h54);
    toggles = 0; highs = 0; prev_beep = beep;
    key_in = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (beep !== prev_beep) toggles++;
      if (beep === 1'b1) highs++;
      prev_beep = beep;
    end
    key_in = 1'b0;
`ifdef MORSE_SIDETONE_EN
    chk("beep_toggles", 64'((toggles >= 18 && toggles <= 20) ? 1 : 0), 64'd1);
`else
    chk("beep_quiet", 64'(highs + toggles), 64'd0);
`endif
    cyc(120);
    chk("pending_commits", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
